// File: rtl/prio_req_scheduler_pkg.sv
// Shared constants and FSM encoding for the priority request scheduler.
// Imported by the scheduler top and its round-robin picker.
package prio_req_scheduler_pkg;

    localparam int DW  = 8;
    localparam int CW  = 3;
    localparam int NCH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/prio_req_scheduler_rr_pick4.sv
// Combinational round-robin picker: first set bit of mask searching
// ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
    import prio_req_scheduler_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  logic [1:0]     ptr,
    output logic [1:0]     ch,
    output logic           any_req
);

    logic [1:0] idx;

    // Walk from the farthest offset down so the nearest hit after ptr wins.
    always_comb begin
        ch      = ptr;
        idx     = ptr;
        any_req = |mask;
        for (int i = NCH; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (mask[idx]) begin
                ch = idx;
            end
        end
    end

endmodule

// File: rtl/prio_req_scheduler.sv
// Sequential front-end for the 4:1 priority-encoding mux: holds four request
// registers, scans them round-robin via S and issues (channel, bit) grants.
module prio_req_scheduler #(
    parameter int DW = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [1:0]    wr_ch,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] I0,
    output logic [DW-1:0] I1,
    output logic [DW-1:0] I2,
    output logic [DW-1:0] I3,
    output logic [1:0]    S,
    input  logic [CW-1:0] F,
    output logic          gnt_valid,
    output logic [1:0]    gnt_ch,
    output logic [CW-1:0] gnt_code,
    input  logic          gnt_ready,
    output logic          busy
);

    import prio_req_scheduler_pkg::*;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   req_q [NCH];
    logic [DW-1:0]   req_d [NCH];
    logic [1:0]      ptr_q;
    logic [1:0]      ptr_d;
    logic [1:0]      s_d;
    logic            gnt_valid_d;
    logic [1:0]      gnt_ch_d;
    logic [CW-1:0]   gnt_code_d;
    logic            clr_en;
    logic [NCH-1:0]  nonempty;
    logic [1:0]      pick_ch;
    logic            any_req;

    always_comb begin
        nonempty = '0;
        for (int c = 0; c < NCH; c++) begin
            nonempty[c] = |req_q[c];
        end
    end

    rr_pick4 u_pick (
        .mask    (nonempty),
        .ptr     (ptr_q),
        .ch      (pick_ch),
        .any_req (any_req)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        s_d         = S;
        gnt_valid_d = gnt_valid;
        gnt_ch_d    = gnt_ch;
        gnt_code_d  = gnt_code;
        clr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    s_d     = pick_ch;
                    state_d = ST_SCAN;
                end
            end
            // S has had a full cycle to settle through the mux.
            ST_SCAN: begin
                gnt_code_d  = F;
                gnt_ch_d    = S;
                gnt_valid_d = 1'b1;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (gnt_valid && gnt_ready) begin
                    clr_en      = 1'b1;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_ch;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear first, then OR the write, so a re-written granted bit stays set.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            req_d[c] = req_q[c];
            if (clr_en && (gnt_ch == 2'(c))) begin
                req_d[c] = req_d[c] & ~(DW'(1) << gnt_code);
            end
            if (wr_en && (wr_ch == 2'(c))) begin
                req_d[c] = req_d[c] | wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd3;
            S         <= 2'd0;
            gnt_valid <= 1'b0;
            gnt_ch    <= 2'd0;
            gnt_code  <= '0;
            for (int c = 0; c < NCH; c++) begin
                req_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            S         <= s_d;
            gnt_valid <= gnt_valid_d;
            gnt_ch    <= gnt_ch_d;
            gnt_code  <= gnt_code_d;
            for (int c = 0; c < NCH; c++) begin
                req_q[c] <= req_d[c];
            end
        end
    end

    assign I0   = req_q[0];
    assign I1   = req_q[1];
    assign I2   = req_q[2];
    assign I3   = req_q[3];
    assign busy = (state_q != ST_IDLE) || any_req;

endmodule

// File: tb/tb_prio_req_scheduler.sv
// Scoreboard bench for prio_req_scheduler attached to a behavioural 4:1
// priority-encoding mux; grant order predicted by a transaction-level model.
module tb_prio_req_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_data;
    logic [7:0] I0, I1, I2, I3;
    logic [1:0] S;
    logic [2:0] F;
    logic       gnt_valid;
    logic [1:0] gnt_ch;
    logic [2:0] gnt_code;
    logic       gnt_ready;
    logic       busy;

    always #5 clk = ~clk;

    prio_req_scheduler #(.DW(8), .CW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .I0        (I0),
        .I1        (I1),
        .I2        (I2),
        .I3        (I3),
        .S         (S),
        .F         (F),
        .gnt_valid (gnt_valid),
        .gnt_ch    (gnt_ch),
        .gnt_code  (gnt_code),
        .gnt_ready (gnt_ready),
        .busy      (busy)
    );

    // The priority-encoding mux: index of the highest set bit of I[S].
    logic [7:0] mux_sel;
    always_comb begin
        mux_sel = I0;
        case (S)
            2'd1:    mux_sel = I1;
            2'd2:    mux_sel = I2;
            2'd3:    mux_sel = I3;
            default: mux_sel = I0;
        endcase
        F = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (mux_sel[b]) F = 3'(b);
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    // Reference model: request sets per channel and last-served channel.
    int m_reg[4];
    int m_ptr;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < 4; c++) m_reg[c] = 0;
        m_ptr = 3;
    endtask

    task automatic m_write(input int ch, input int data);
        m_reg[ch] = m_reg[ch] | data;
    endtask

    function automatic int m_next_ch();
        for (int k = 1; k <= 4; k++) begin
            if (m_reg[(m_ptr + k) % 4] != 0) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic m_grant_one();
        int c;
        int code;
        c = m_next_ch();
        if (c >= 0) begin
            code = 0;
            for (int b = 0; b < 8; b++) if (((m_reg[c] >> b) & 1) != 0) code = b;
            m_reg[c] = m_reg[c] - (1 << code);
            m_ptr = c;
            exp_q.push_back(c * 8 + code);
        end
    endtask

    task automatic m_drain();
        while (m_next_ch() >= 0) m_grant_one();
    endtask

    // Monitor: pops an expectation on every accepted grant.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst   = 1'b0;
    logic [1:0] prev_ch    = 2'd0;
    logic [2:0] prev_code  = 3'd0;

    always @(negedge clk) begin
        int e;
        if (rst_n && prev_rst && prev_valid && !prev_ready) begin
            check("hold_valid", int'(gnt_valid), 1);
            check("hold_ch", int'(gnt_ch), int'(prev_ch));
            check("hold_code", int'(gnt_code), int'(prev_code));
        end
        if (rst_n && gnt_valid) begin
            check("sel_matches_ch", int'(S), int'(gnt_ch));
            if (gnt_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", int'(gnt_ch) * 8 + int'(gnt_code), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_ch", int'(gnt_ch), e / 8);
                    check("grant_code", int'(gnt_code), e % 8);
                end
            end
        end
        prev_valid = gnt_valid;
        prev_ready = gnt_ready;
        prev_rst   = rst_n;
        prev_ch    = gnt_ch;
        prev_code  = gnt_code;
    end

    task automatic do_write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_data = 8'(data);
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (gnt_valid) seen = 1'b1;
        end
        if (!seen) check(name, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name, input bit rand_rdy);
        bit done = 1'b0;
        for (int n = 0; n < 600 && !done; n++) begin
            @(posedge clk); #1;
            if (rand_rdy) gnt_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!busy && !gnt_valid && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check(name, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_I0"}, int'(I0), 0);
        check({tag, "_I1"}, int'(I1), 0);
        check({tag, "_I2"}, int'(I2), 0);
        check({tag, "_I3"}, int'(I3), 0);
        check({tag, "_S"}, int'(S), 0);
        check({tag, "_valid"}, int'(gnt_valid), 0);
        check({tag, "_ch"}, int'(gnt_ch), 0);
        check({tag, "_code"}, int'(gnt_code), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int mask;
        int data[4];
        int first;
        int c;

        rst_n = 1'b0; wr_en = 1'b0; wr_ch = 2'd0; wr_data = 8'd0; gnt_ready = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;

        // Two grants from one channel, highest bit first.
        gnt_ready = 1'b1;
        m_write(0, 8'h81); m_drain();
        do_write(0, 8'h81);
        wait_idle("t1_idle", 1'b0);
        check("t1_I0_clear", int'(I0), 0);
        check("t1_busy", int'(busy), 0);

        // Two channels written in the same idle window.
        m_write(1, 8'h10); m_write(3, 8'h04); m_drain();
        do_write(1, 8'h10);
        do_write(3, 8'h04);
        wait_idle("t2_idle", 1'b0);

        // Round-robin interleave between channels 0 and 2.
        m_write(0, 8'h03); m_write(2, 8'h03); m_drain();
        do_write(0, 8'h03);
        do_write(2, 8'h03);
        wait_idle("t3_idle", 1'b0);

        // Back-pressure on (2,5) with a higher bit arriving mid-grant.
        gnt_ready = 1'b0;
        m_write(2, 8'h20); m_grant_one(); m_write(2, 8'h80); m_drain();
        do_write(2, 8'h20);
        wait_valid("t4_valid");
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                do_write(2, 8'h80);
            end else begin
                @(posedge clk); #1;
            end
            check("t4_bit5_held", int'(I2[5]), 1);
        end
        gnt_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_bit5_cleared", int'(I2), 8'h80);
        @(posedge clk); #1;
        wait_idle("t4_idle", 1'b0);

        // Clear and re-set of the same bit on the same edge.
        gnt_ready = 1'b0;
        m_write(1, 8'h08); m_grant_one(); m_write(1, 8'h08); m_drain();
        do_write(1, 8'h08);
        wait_valid("t5_valid");
        gnt_ready = 1'b1;
        do_write(1, 8'h08);
        @(negedge clk);
        check("t5_set_wins", int'(I1), 8'h08);
        @(posedge clk); #1;
        wait_idle("t5_idle", 1'b0);

        // Reset while a grant is pending drops it.
        gnt_ready = 1'b0;
        do_write(3, 8'h40);
        wait_valid("t6_valid");
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        check_reset_state("midreset");
        gnt_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t6_no_grant", int'(gnt_valid), 0);
        end
        @(posedge clk); #1;

        // Random batches, one write per channel, nearest-after-ptr channel first.
        for (int b = 0; b < 40; b++) begin
            gnt_ready = 1'b0;
            mask = int'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) data[k] = int'($urandom_range(1, 255));
            first = 0;
            for (int k = 4; k >= 1; k--) if (((mask >> ((m_ptr + k) % 4)) & 1) != 0) first = (m_ptr + k) % 4;
            for (int k = 0; k < 4; k++) begin
                c = (first + k) % 4;
                if (((mask >> c) & 1) != 0) m_write(c, data[c]);
            end
            m_drain();
            for (int k = 0; k < 4; k++) begin
                c = (first + k) % 4;
                if (((mask >> c) & 1) != 0) do_write(c, data[c]);
            end
            wait_idle("rand_idle", 1'b1);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
